// File: rtl/ahb_sram_slv.sv
// ahb_sram_slv: AHB scratch-RAM slave with byte-lane writes, programmable wait
// states and the two-cycle ERROR response for out-of-range, illegal-size or misaligned beats.
module ahb_sram_slv #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      clk,
    input  logic                      ahb_slv_hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_slv_haddr,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_slv_hwdata,
    input  logic [2:0]                ahb_slv_hsize,
    input  logic [2:0]                ahb_slv_hburst,
    input  logic [1:0]                ahb_slv_htrans,
    input  logic                      ahb_slv_hwrite,
    output logic [AHB_DATA_WIDTH-1:0] slv_ahb_hrdata,
    output logic                      slv_ahb_hready,
    output logic [1:0]                slv_ahb_hresp
);
    localparam int IW = $clog2(MEM_DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [IW+1:0] addr_q, addr_d;
    logic [1:0] size_q, size_d;
    logic write_q, write_d, valid_q, valid_d;
    logic accept, err, commit;
    logic [3:0] be;
    logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic unused_ok;
    assign unused_ok = ^{ahb_slv_hburst, ahb_slv_htrans[0]};
    assign slv_ahb_hready = !(state_q == WAIT || state_q == ERR1);
    assign slv_ahb_hresp = {1'b0, state_q == ERR1 || state_q == ERR2};
    assign accept = slv_ahb_hready && ahb_slv_htrans[1];
    assign err = (|ahb_slv_haddr[AHB_ADDR_WIDTH-1:IW+2]) || (ahb_slv_hsize > 3'd2)
              || (ahb_slv_hsize == 3'd1 && ahb_slv_haddr[0])
              || (ahb_slv_hsize == 3'd2 && |ahb_slv_haddr[1:0]);
    // valid_q only ever marks OKAY beats, so hready alone identifies the completing cycle
    assign commit = valid_q && write_q && slv_ahb_hready;
    assign be = (size_q == 2'd0) ? 4'b0001 << addr_q[1:0]
              : (size_q == 2'd1) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign slv_ahb_hrdata = (valid_q && !write_q && slv_ahb_hready) ? mem[addr_q[IW+1:2]] : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        valid_d = valid_q;
        if (state_q == WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? DATA : WAIT;
        end else if (state_q == ERR1) begin
            state_d = ERR2;
        end else begin
            valid_d = accept && !err;
            state_d = !accept ? IDLE : err ? ERR1 : (WAIT_STATES > 0) ? WAIT : IDLE;
            cnt_d   = (accept && !err) ? 4'(WAIT_STATES) : 4'd0;
            if (accept) begin
                addr_d  = ahb_slv_haddr[IW+1:0];
                size_d  = ahb_slv_hsize[1:0];
                write_d = ahb_slv_hwrite;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!ahb_slv_hreset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            valid_q <= valid_d;
        end
    end
    // memory is deliberately not reset; a reset edge suppresses any pending commit
    always_ff @(posedge clk) begin
        if (ahb_slv_hreset_n && commit)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[IW+1:2]][8*b +: 8] <= ahb_slv_hwdata[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slv.sv
// tb_ahb_sram_slv: scoreboard bench driving three slaves (0, 3 and 2 wait states)
// through a pipelined AHB master model with a reference memory.
module tb_ahb_sram_slv;
    localparam int MD = 64;
    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;
    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lows;
    } exp_t;
    logic clk = 0, hreset_n = 0, hwrite = 0;
    logic [31:0] haddr = 0, hwdata = 0;
    logic [2:0] hsize = 0, hburst = 0;
    logic [1:0] htrans = 0;
    logic [31:0] rd [3];
    logic rdy [3];
    logic [1:0] rsp [3];
    logic [1:0] tr [3];
    int sel = 0, checks = 0, failures = 0;
    beat_t bq[$];
    exp_t sq[$];
    logic [31:0] model [int];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign tr[g] = (sel == g) ? htrans : 2'b00;
        ahb_sram_slv #(.MEM_DEPTH(MD), .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 2)) u_dut (
            .clk(clk), .ahb_slv_hreset_n(hreset_n), .ahb_slv_haddr(haddr),
            .ahb_slv_hwdata(hwdata), .ahb_slv_hsize(hsize), .ahb_slv_hburst(hburst),
            .ahb_slv_htrans(tr[g]), .ahb_slv_hwrite(hwrite), .slv_ahb_hrdata(rd[g]),
            .slv_ahb_hready(rdy[g]), .slv_ahb_hresp(rsp[g]));
    end
    function automatic int ws(int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : 2;
    endfunction
    function automatic beat_t mk(logic [1:0] t, logic [31:0] a, logic [2:0] s, logic w, logic [31:0] d);
        beat_t b;
        b.trans = t; b.addr = a; b.size = s; b.wr = w; b.wdata = d;
        return b;
    endfunction
    function automatic bit is_err(beat_t b);
        return (b.addr[31:2] >= MD) || (b.size > 2) || (b.size == 1 && b.addr[0])
            || (b.size == 2 && b.addr[1:0] != 0);
    endfunction
    function automatic void model_write(beat_t b);
        int k = sel * MD + int'(b.addr[31:2]);
        int nb = 1 << b.size;
        int lo = int'(b.addr[1:0]);
        logic [31:0] w = model.exists(k) ? model[k] : 32'h0;
        for (int l = 0; l < 4; l++)
            if (l >= lo && l < lo + nb) w[8*l +: 8] = b.wdata[8*l +: 8];
        model[k] = w;
    endfunction
    function automatic logic [31:0] model_rd(logic [31:0] a);
        int k = sel * MD + int'(a[31:2]);
        return model.exists(k) ? model[k] : 32'h0;
    endfunction
    task automatic run(input string name, output int span);
        beat_t acc, dp;
        exp_t e;
        bit acc_new = 0, pend = 0;
        int lows = 0, t = 0, t0 = -1, t1 = 0, guard = 0;
        while ((bq.size() > 0 || pend || acc_new) && guard < 300) begin
            @(negedge clk);
            t++; guard++;
            if (acc_new) begin
                dp = acc; hwdata = dp.wdata; pend = 1; acc_new = 0; lows = 0;
            end
            if (pend && !rdy[sel]) begin
                lows++;
                e = sq[0];
                checks++;
                if (rsp[sel] !== {1'b0, e.err}) begin
                    failures++;
                    $display("FAIL %s wait_hresp got=%0d exp=%0d", name, rsp[sel], e.err);
                end
            end else if (pend) begin
                e = sq.pop_front();
                checks++;
                if (rsp[sel] !== {1'b0, e.err}) begin
                    failures++;
                    $display("FAIL %s hresp addr=%h got=%0d exp=%0d", name, dp.addr, rsp[sel], e.err);
                end
                checks++;
                if (rd[sel] !== e.rdata) begin
                    failures++;
                    $display("FAIL %s hrdata addr=%h got=%h exp=%h", name, dp.addr, rd[sel], e.rdata);
                end
                checks++;
                if (lows !== e.lows) begin
                    failures++;
                    $display("FAIL %s wait_cycles addr=%h got=%0d exp=%0d", name, dp.addr, lows, e.lows);
                end
                if (!e.err && dp.wr) model_write(dp);
                pend = 0; t1 = t;
            end else begin
                checks++;
                if (rdy[sel] !== 1'b1 || rsp[sel] !== 2'd0 || rd[sel] !== 32'h0) begin
                    failures++;
                    $display("FAIL %s idle got=%b/%0d/%h exp=1/0/0", name, rdy[sel], rsp[sel], rd[sel]);
                end
            end
            if (rdy[sel]) begin
                if (bq.size() > 0) begin
                    acc = bq.pop_front();
                    htrans = acc.trans; haddr = acc.addr; hsize = acc.size; hwrite = acc.wr;
                    if (t0 < 0) t0 = t;
                    if (acc.trans[1]) begin
                        acc_new = 1;
                        e.err = is_err(acc);
                        e.rdata = (e.err || acc.wr) ? 32'h0 : model_rd(acc.addr);
                        e.lows = e.err ? 1 : ws(sel);
                        sq.push_back(e);
                    end
                end else htrans = 2'b00;
            end
        end
        if (guard >= 300) begin
            checks++; failures++;
            $display("FAIL %s timeout got=%0d cycles exp<300", name, guard);
            bq.delete(); sq.delete();
        end
        htrans = 2'b00;
        span = t1 - t0;
    endtask
    task automatic test_reset();
        hreset_n = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rdy[s] !== 1'b1 || rsp[s] !== 2'd0 || rd[s] !== 32'h0) begin
                failures++;
                $display("FAIL reset dut%0d got=%b/%0d/%h exp=1/0/0", s, rdy[s], rsp[s], rd[s]);
            end
        end
        hreset_n = 1;
    endtask
    task automatic test_back_to_back();
        int span;
        sel = 0;
        bq.push_back(mk(2'd2, 32'h10, 3'd2, 1, 32'hDEADBEEF));
        bq.push_back(mk(2'd2, 32'h10, 3'd2, 0, 32'h0));
        run("b2b", span);
        checks++;
        if (span !== 2) begin
            failures++;
            $display("FAIL b2b span got=%0d exp=2", span);
        end
    endtask
    task automatic test_byte_lanes();
        int span;
        sel = 0;
        bq.push_back(mk(2'd2, 32'h20, 3'd2, 1, 32'h0));
        bq.push_back(mk(2'd2, 32'h21, 3'd0, 1, 32'h0000AB00));
        bq.push_back(mk(2'd2, 32'h22, 3'd1, 1, 32'h12340000));
        bq.push_back(mk(2'd2, 32'h20, 3'd2, 0, 32'h0));
        bq.push_back(mk(2'd2, 32'h24, 3'd2, 1, 32'hFFFFFFFF));
        bq.push_back(mk(2'd2, 32'h24, 3'd1, 1, 32'h00005A5A));
        bq.push_back(mk(2'd2, 32'h27, 3'd0, 1, 32'h00000000));
        bq.push_back(mk(2'd2, 32'h24, 3'd2, 0, 32'h0));
        run("lanes", span);
    endtask
    task automatic test_wait_states();
        int span;
        sel = 1;
        for (int i = 0; i < 4; i++) bq.push_back(mk(2'd2, 32'h40 + 4 * i, 3'd2, 1, 32'hA0000000 + i));
        run("ws_fill", span);
        bq.push_back(mk(2'd2, 32'h44, 3'd2, 0, 32'h0));
        run("ws_single", span);
        hburst = 3'd1;
        for (int i = 0; i < 4; i++) bq.push_back(mk((i == 0) ? 2'd2 : 2'd3, 32'h40 + 4 * i, 3'd2, 0, 32'h0));
        run("ws_burst", span);
        hburst = 3'd0;
        checks++;
        if (span !== 16) begin
            failures++;
            $display("FAIL ws_burst span got=%0d exp=16", span);
        end
    endtask
    task automatic test_errors();
        int span;
        sel = 0;
        bq.push_back(mk(2'd2, 32'h0, 3'd2, 1, 32'h11223344));
        bq.push_back(mk(2'd2, 32'h4, 3'd2, 1, 32'h55667788));
        bq.push_back(mk(2'd2, MD * 4, 3'd2, 0, 32'h0));
        bq.push_back(mk(2'd2, 32'h2, 3'd2, 1, 32'hBADBAD00));
        bq.push_back(mk(2'd2, 32'h4, 3'd3, 1, 32'hBADBAD11));
        bq.push_back(mk(2'd2, 32'h5, 3'd1, 1, 32'hBADBAD22));
        bq.push_back(mk(2'd2, 32'h0, 3'd2, 0, 32'h0));
        bq.push_back(mk(2'd2, 32'h4, 3'd2, 0, 32'h0));
        run("err", span);
        sel = 1;
        bq.push_back(mk(2'd2, 32'h42, 3'd2, 1, 32'hBADBAD33));
        bq.push_back(mk(2'd2, 32'h40, 3'd2, 0, 32'h0));
        run("err_ws", span);
    endtask
    task automatic test_idle_busy();
        int span;
        sel = 0;
        bq.push_back(mk(2'd2, 32'h30, 3'd2, 1, 32'hCAFEF00D));
        bq.push_back(mk(2'd1, 32'h30, 3'd2, 1, 32'h0BADF00D));
        bq.push_back(mk(2'd0, 32'h30, 3'd2, 1, 32'h0BADF00D));
        bq.push_back(mk(2'd1, 32'h30, 3'd0, 1, 32'h0BADF00D));
        bq.push_back(mk(2'd2, 32'h30, 3'd2, 0, 32'h0));
        run("idle_busy", span);
    endtask
    task automatic test_reset_mid_op();
        int span;
        sel = 2;
        bq.push_back(mk(2'd2, 32'h30, 3'd2, 1, 32'h600DCAFE));
        run("rst_pre", span);
        @(negedge clk);
        haddr = 32'h30; hsize = 3'd2; hwrite = 1; htrans = 2'd2;
        @(negedge clk);
        htrans = 2'd0; hwdata = 32'hDEAD0000;
        checks++;
        if (rdy[sel] !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait hready got=%b exp=0", rdy[sel]);
        end
        hreset_n = 0;
        @(negedge clk);
        hreset_n = 1;
        checks++;
        if (rdy[sel] !== 1'b1 || rsp[sel] !== 2'd0 || rd[sel] !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%0d/%h exp=1/0/0", rdy[sel], rsp[sel], rd[sel]);
        end
        repeat (4) @(negedge clk);
        bq.push_back(mk(2'd2, 32'h30, 3'd2, 0, 32'h0));
        run("rst_post", span);
    endtask
    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_idle_busy();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
